// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: control bit map,
// MIPS32 opcode/funct codes and the control word type.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 13;

  localparam int ALU_CTRL_CLZ  = 12;
  localparam int ALU_CTRL_ADD  = 11;
  localparam int ALU_CTRL_SUB  = 10;
  localparam int ALU_CTRL_SLT  = 9;
  localparam int ALU_CTRL_SLTU = 8;
  localparam int ALU_CTRL_AND  = 7;
  localparam int ALU_CTRL_NOR  = 6;
  localparam int ALU_CTRL_OR   = 5;
  localparam int ALU_CTRL_XOR  = 4;
  localparam int ALU_CTRL_SLL  = 3;
  localparam int ALU_CTRL_SRL  = 2;
  localparam int ALU_CTRL_SRA  = 1;
  localparam int ALU_CTRL_LUI  = 0;

  typedef logic [CTRL_W-1:0] alu_ctrl_t;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [5:0] F_CLZ  = 6'h20;

  function automatic alu_ctrl_t ctrl_bit(input int idx);
    return alu_ctrl_t'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational MIPS32 ALU decoder and operand select.
// Macro ALU_ISSUE_CLZ_EN enables SPECIAL2 clz decode.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rs_value,
  input  logic [DATA_W-1:0] rt_value,
  output alu_ctrl_t         ctrl,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [4:0]        dest,
  output logic              ov_check,
  output logic              illegal
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;

  assign op     = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'b0, imm};

  // Decode opcode/funct; illegal encodings squash all fields.
  always_comb begin
    ctrl     = '0;
    src1     = rs_value;
    src2     = rt_value;
    dest     = rd;
    ov_check = 1'b0;
    illegal  = 1'b0;
    unique case (op)
      OP_SPECIAL: begin
        unique case (funct)
          F_SLL: begin
            ctrl    = ctrl_bit(ALU_CTRL_SLL);
            src1    = {27'b0, shamt};
            illegal = (rs != 5'd0);
          end
          F_SRL: begin
            ctrl    = ctrl_bit(ALU_CTRL_SRL);
            src1    = {27'b0, shamt};
            illegal = (rs != 5'd0);
          end
          F_SRA: begin
            ctrl    = ctrl_bit(ALU_CTRL_SRA);
            src1    = {27'b0, shamt};
            illegal = (rs != 5'd0);
          end
          F_SLLV: ctrl = ctrl_bit(ALU_CTRL_SLL);
          F_SRLV: ctrl = ctrl_bit(ALU_CTRL_SRL);
          F_SRAV: ctrl = ctrl_bit(ALU_CTRL_SRA);
          F_ADD: begin
            ctrl     = ctrl_bit(ALU_CTRL_ADD);
            ov_check = 1'b1;
          end
          F_ADDU: ctrl = ctrl_bit(ALU_CTRL_ADD);
          F_SUB: begin
            ctrl     = ctrl_bit(ALU_CTRL_SUB);
            ov_check = 1'b1;
          end
          F_SUBU: ctrl = ctrl_bit(ALU_CTRL_SUB);
          F_AND:  ctrl = ctrl_bit(ALU_CTRL_AND);
          F_OR:   ctrl = ctrl_bit(ALU_CTRL_OR);
          F_XOR:  ctrl = ctrl_bit(ALU_CTRL_XOR);
          F_NOR:  ctrl = ctrl_bit(ALU_CTRL_NOR);
          F_SLT:  ctrl = ctrl_bit(ALU_CTRL_SLT);
          F_SLTU: ctrl = ctrl_bit(ALU_CTRL_SLTU);
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctrl     = ctrl_bit(ALU_CTRL_ADD);
        src2     = imm_sx;
        dest     = rt;
        ov_check = 1'b1;
      end
      OP_ADDIU: begin
        ctrl = ctrl_bit(ALU_CTRL_ADD);
        src2 = imm_sx;
        dest = rt;
      end
      OP_SLTI: begin
        ctrl = ctrl_bit(ALU_CTRL_SLT);
        src2 = imm_sx;
        dest = rt;
      end
      OP_SLTIU: begin
        ctrl = ctrl_bit(ALU_CTRL_SLTU);
        src2 = imm_sx;
        dest = rt;
      end
      OP_ANDI: begin
        ctrl = ctrl_bit(ALU_CTRL_AND);
        src2 = imm_zx;
        dest = rt;
      end
      OP_ORI: begin
        ctrl = ctrl_bit(ALU_CTRL_OR);
        src2 = imm_zx;
        dest = rt;
      end
      OP_XORI: begin
        ctrl = ctrl_bit(ALU_CTRL_XOR);
        src2 = imm_zx;
        dest = rt;
      end
      OP_LUI: begin
        ctrl = ctrl_bit(ALU_CTRL_LUI);
        src2 = imm_zx;
        dest = rt;
      end
`ifdef ALU_ISSUE_CLZ_EN
      OP_SPECIAL2: begin
        if (funct == F_CLZ) begin
          ctrl = ctrl_bit(ALU_CTRL_CLZ);
          src2 = '0;
        end else begin
          illegal = 1'b1;
        end
      end
`endif
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl     = '0;
      src1     = '0;
      src2     = '0;
      dest     = 5'd0;
      ov_check = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode-to-execute issue stage: one registered slot with
// valid/ready on both sides. Macro ALU_ISSUE_CLZ_EN adds clz.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_rs_value,
  input  logic [DATA_W-1:0] in_rt_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_control,
  output logic [DATA_W-1:0] out_alu_src1,
  output logic [DATA_W-1:0] out_alu_src2,
  output logic [4:0]        out_dest,
  output logic              out_ov_check,
  output logic              out_illegal
);

  alu_ctrl_t         d_ctrl;
  logic [DATA_W-1:0] d_src1;
  logic [DATA_W-1:0] d_src2;
  logic [4:0]        d_dest;
  logic              d_ov;
  logic              d_ill;
  logic              load;

  alu_issue_dec u_dec (
    .inst     (in_inst),
    .rs_value (in_rs_value),
    .rt_value (in_rt_value),
    .ctrl     (d_ctrl),
    .src1     (d_src1),
    .src2     (d_src2),
    .dest     (d_dest),
    .ov_check (d_ov),
    .illegal  (d_ill)
  );

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Slot register; flush kills both held and incoming ops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid       <= 1'b0;
      out_alu_control <= '0;
      out_alu_src1    <= '0;
      out_alu_src2    <= '0;
      out_dest        <= 5'd0;
      out_ov_check    <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_alu_control <= d_ctrl;
      out_alu_src1    <= d_src1;
      out_alu_src2    <= d_src2;
      out_dest        <= d_dest;
      out_ov_check    <= d_ov;
      out_illegal     <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed MIPS32 vectors,
// expected fields pushed at accept, monitor pops on output.
module tb_alu_issue;

  typedef struct packed {
    logic [12:0] ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        ov;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_rs_value = '0;
  logic [31:0] in_rt_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_alu_control;
  logic [31:0] out_alu_src1;
  logic [31:0] out_alu_src2;
  logic [4:0]  out_dest;
  logic        out_ov_check;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb[$];
  int pop_cyc[$];

  alu_issue dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_inst         (in_inst),
    .in_rs_value     (in_rs_value),
    .in_rt_value     (in_rt_value),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_alu_control (out_alu_control),
    .out_alu_src1    (out_alu_src1),
    .out_alu_src2    (out_alu_src2),
    .out_dest        (out_dest),
    .out_ov_check    (out_ov_check),
    .out_illegal     (out_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [12:0] c,
                              input logic [31:0] a,
                              input logic [31:0] b,
                              input logic [4:0] d,
                              input logic o,
                              input logic i);
    exp_t e;
    e.ctrl = c; e.s1 = a; e.s2 = b;
    e.dest = d; e.ov = o; e.ill = i;
    return e;
  endfunction

  function automatic exp_t cur();
    return mk(out_alu_control, out_alu_src1, out_alu_src2,
              out_dest, out_ov_check, out_illegal);
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every output handshake must match the oldest entry.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      exp_t g;
      exp_t e;
      g = cur();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h want none", g);
      end else begin
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if (g !== e) begin
          errors++;
          $display("FAIL output_fields: got %h want %h", g, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] inst,
                      input logic [31:0] rs,
                      input logic [31:0] rt,
                      input exp_t e,
                      input bit push);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_inst = inst;
    in_rs_value = rs;
    in_rt_value = rt;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready want accept of %h",
               inst);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  exp_t ill_e;
  exp_t add_e;
  exp_t snap;

  initial begin
    ill_e = mk(13'h0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    idle(3);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_data", 64'(cur() != '0), 64'd0);
    @(posedge clk);
    #1;

    // Single ops
    send(32'h2109FFFF, 32'd5, 32'h77,
         mk(13'h0800, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0), 1);
    send(32'h00095100, 32'h1234, 32'h0F,
         mk(13'h0008, 32'd4, 32'h0F, 5'd10, 1'b0, 1'b0), 1);
    idle(2);

    // Back-to-back, no bubble
    send(32'h3508ABCD, 32'h1111, 32'h0,
         mk(13'h0020, 32'h1111, 32'h0000ABCD, 5'd8, 1'b0, 1'b0), 1);
    send(32'h3C011234, 32'h2222, 32'h0,
         mk(13'h0001, 32'h2222, 32'h00001234, 5'd1, 1'b0, 1'b0), 1);
    idle(2);
    if (pop_cyc.size() >= 2)
      chk("no_bubble", 64'(pop_cyc[$] - pop_cyc[$-1]), 64'd1);
    else
      chk("no_bubble_count", 64'(pop_cyc.size()), 64'd4);

    // More decode coverage
    send(32'h0109502A, 32'h3, 32'h4,
         mk(13'h0200, 32'h3, 32'h4, 5'd10, 1'b0, 1'b0), 1);
    send(32'h01095007, 32'h1F, 32'h80000000,
         mk(13'h0002, 32'h1F, 32'h80000000, 5'd10, 1'b0, 1'b0), 1);
    send(32'h2D098000, 32'h9, 32'h0,
         mk(13'h0100, 32'h9, 32'hFFFF8000, 5'd9, 1'b0, 1'b0), 1);
    send(32'h31098000, 32'h9, 32'h0,
         mk(13'h0080, 32'h9, 32'h00008000, 5'd9, 1'b0, 1'b0), 1);
    send(32'h01090020, 32'h6, 32'h7,
         mk(13'h0800, 32'h6, 32'h7, 5'd0, 1'b1, 1'b0), 1);
    idle(2);

    // Backpressure
    add_e = mk(13'h0800, 32'h10, 32'h20, 5'd10, 1'b1, 1'b0);
    out_ready = 1'b0;
    send(32'h01095020, 32'h10, 32'h20, add_e, 1);
    in_valid = 1'b1;
    in_inst = 32'h01095022;
    in_rs_value = 32'h30;
    in_rt_value = 32'h7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      snap = cur();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      checks++;
      if (snap !== add_e) begin
        errors++;
        $display("FAIL bp_stable: got %h want %h", snap, add_e);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'h01095022, 32'h30, 32'h7,
         mk(13'h0400, 32'h30, 32'h7, 5'd10, 1'b1, 1'b0), 1);
    send(32'h01095023, 32'h1, 32'h2,
         mk(13'h0400, 32'h1, 32'h2, 5'd10, 1'b0, 1'b0), 1);
    idle(2);

    // Illegal encodings
    send(32'h0000003F, 32'hAA, 32'hBB, ill_e, 1);
    send(32'h00295100, 32'h5, 32'h6, ill_e, 1);
`ifdef ALU_ISSUE_CLZ_EN
    send(32'h71004820, 32'h00F00000, 32'h55,
         mk(13'h1000, 32'h00F00000, 32'h0, 5'd9, 1'b0, 1'b0), 1);
`else
    send(32'h71004820, 32'h00F00000, 32'h55, ill_e, 1);
`endif
    idle(2);

    // Flush with held op plus concurrent load
    out_ready = 1'b0;
    send(32'h01095025, 32'h1, 32'h2, ill_e, 0);
    in_valid = 1'b1;
    in_inst = 32'h01095026;
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle(2);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h01095024, 32'h1, 32'h2, ill_e, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ctrl", 64'(out_alu_control), 64'd0);
    #3;
    resetn = 1'b1;
    out_ready = 1'b1;
    idle(3);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Decode-to-execute stage that feeds the integer ALU. It decodes a MIPS32 integer ALU instruction into the 13-bit one-hot ALU control word. It selects and extends the two ALU operands. It registers the result in a single pipeline slot with valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, operand width; only 32 is supported.
CTRL_W, 13, ALU control width; one-hot.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held slot and incoming transfer
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_rs_value  in  32  GPR[rs]
in_rt_value  in  32  GPR[rt]
out_valid  out  1  slot holds a decoded op
out_ready  in  1  ALU stage accepts
out_alu_control  out  13  one-hot ALU control, bit map below
out_alu_src1  out  32  ALU operand 1; shift amount in [4:0] for shifts
out_alu_src2  out  32  ALU operand 2
out_dest  out  5  destination GPR; 0 when illegal
out_ov_check  out  1  trap on ALU overflow (add/sub/addi only)
out_illegal  out  1  reserved/undecoded instruction

Behaviour:
- Control bit map: [12] clz, [11] add, [10] sub, [9] slt, [8] sltu, [7] and, [6] nor, [5] or, [4] xor, [3] sll, [2] srl, [1] sra, [0] lui. At most one bit is set.
- Reset: out_valid=0 and all data outputs 0. in_ready=1 when resetn is high and out_valid=0.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational from out_ready).
  - Load on in_valid & in_ready.
  - out_valid clears when out_ready=1 and there is no load.
  - Outputs hold stable while out_valid & !out_ready.
  - Latency is 1 cycle. Throughput is 1 per cycle under continuous out_ready.
- flush=1: out_valid<=0 next cycle. The incoming transfer is discarded, and flush dominates a load.
- SPECIAL (op 0x00) funct decode:
  - 00 sll, 02 srl, 03 sra: src1={27'b0,shamt}, src2=rt_value.
  - 04 sllv, 06 srlv, 07 srav: src1=rs_value, src2=rt_value.
  - 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu: src1=rs, src2=rt.
  - dest=rd.
- I-type decode (dest=rt, src1=rs_value):
  - 08 addi, 09 addiu, 0A slti, 0B sltiu: src2 = sign-extended imm. sltiu also uses sign extension.
  - 0C andi, 0D ori, 0E xori: src2 = zero-extended imm.
  - 0F lui: src2 = zero-extended imm. The ALU performs the 16-bit shift.
- subu maps to sub with ov_check=0. addu/addiu map to add with ov_check=0. ov_check=1 only for add, addi, sub.
- Illegal instruction: any other opcode/funct, or SPECIAL shift funct with rs!=0. Result: control=0, src1=src2=0, dest=0, ov_check=0, illegal=1. It still handshakes normally.
- dest=0 is legal and is passed through.

Optional Feature:
ALU_ISSUE_CLZ_EN:
- Defined: SPECIAL2 (op 0x1C) funct 0x20 (clz) decodes to control bit 12, src1=rs_value, src2=0, dest=rd.
- Undefined: that encoding is illegal and control bit 12 is never set.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_CTRL_* bit-index constants.
  - opcode/funct localparams.
  - alu_ctrl_t (13-bit) typedef.
- One combinational sub-module, alu_issue_dec (instruction and operands in; control/src1/src2/dest/ov_check/illegal out). The top level holds only the handshake register.

Test Plan:
1. addi: inst=0x2109FFFF, rs_value=5, in_valid=1, out_ready=1 -> next cycle out_valid=1, control=13'h0800, src1=5, src2=0xFFFFFFFF, dest=9, ov_check=1, illegal=0.
2. sll: inst=0x00095100, rt_value=0x0000000F -> control=13'h0008, src1=4, src2=0x0000000F, dest=10.
3. ori then lui back-to-back:
   - 0x3508ABCD -> control=13'h0020, src2=0x0000ABCD, dest=8.
   - 0x3C011234 -> control=13'h0001, src2=0x00001234, dest=1.
   - Result: two consecutive out_valid cycles with no bubble.
4. Backpressure: load inst=0x01095020 (add), then hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs stable. Release -> accepted ops appear in order, none lost or duplicated.
5. inst=0x0000003F -> illegal=1, control=0, dest=0. Flush asserted while holding a valid op plus a concurrent load -> out_valid=0 next cycle. resetn low mid-stream -> out_valid=0 immediately.
6. inst=0x71004820, rs_value=0x00F00000:
   - With ALU_ISSUE_CLZ_EN: control=13'h1000, src1=0x00F00000, dest=9.
   - Without: illegal=1.
